mux4_rr_arbiter: RTL

- Round-robin arbiter and sequencer for a shared 4:1 output multiplexer.
- Four requesters compete for a single output path. The block grants one requester at a time, drives the mux select, and registers the selected data onto z.
- Tenure is capped by MAX_HOLD when other requesters are waiting, which guarantees fairness.
- It is the controlling wrapper around the 4:1 mux datapath in the simulation/system hierarchy.

---
 rtl/mux4_rr_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 output multiplexer.
// One requester owns the output path at a time. Its tenure is capped at
// MAX_HOLD consecutive cycles while anyone else is waiting. The selected
// data is registered onto z one cycle behind the grant.
//
// Handshake: req[i] is a level request sampled at every rising edge.
// gnt[i] is the registered answer and stays high for as long as requester i
// owns the path. A requester that drops req loses the grant at the next edge.
module mux4_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             busy,
    output logic [WIDTH-1:0] z
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [3:0] MAX_CNT = 4'(MAX_HOLD);

    // FSM state; kept as a named signal so checkers can bind to it
    logic [0:0] state;
    logic [0:0] state_nxt;

    logic [3:0] hold_cnt;
    logic [3:0] hold_nxt;
    logic [1:0] last_ptr;
    logic [1:0] last_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] sel_nxt;
    logic       busy_nxt;

    logic [3:0] owner_mask;
    logic [3:0] others;
    logic [2:0] pick_all;
    logic [2:0] pick_oth;
    logic       rel_a;
    logic       rel_b;
    logic [WIDTH-1:0] d_sel;

    // Returns {found, index}. Searches ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
    // The loop runs from the farthest slot down to the nearest one, so the
    // nearest set bit overwrites the result last and wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

    assign owner_mask = 4'b0001 << sel;
    assign others     = req & ~owner_mask;
    assign pick_all   = rr_pick(req, last_ptr);
    // In GRANT, last_ptr equals the owner, so this search starts just past it
    assign pick_oth   = rr_pick(others, last_ptr);
    assign rel_a      = ~req[sel];
    assign rel_b      = (hold_cnt == MAX_CNT) && (others != 4'b0000);

    // Next-state and next-grant decision
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        busy_nxt  = busy;
        last_nxt  = last_ptr;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                gnt_nxt  = 4'b0000;
                busy_nxt = 1'b0;
                if (pick_all[2]) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 4'b0001 << pick_all[1:0];
                    sel_nxt   = pick_all[1:0];
                    busy_nxt  = 1'b1;
                    last_nxt  = pick_all[1:0];
                    hold_nxt  = 4'd1;
                end
            end
            GRANT: begin
                if (rel_a || rel_b) begin
                    if (pick_oth[2]) begin
                        // Hand over directly, without an idle bubble
                        gnt_nxt  = 4'b0001 << pick_oth[1:0];
                        sel_nxt  = pick_oth[1:0];
                        last_nxt = pick_oth[1:0];
                        hold_nxt = 4'd1;
                    end else begin
                        // Nobody else is waiting; sel keeps its last value
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                        busy_nxt  = 1'b0;
                        hold_nxt  = 4'd0;
                    end
                end else if (hold_cnt != MAX_CNT) begin
                    hold_nxt = hold_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                busy_nxt  = 1'b0;
                hold_nxt  = 4'd0;
            end
        endcase
    end

    // Data mux driven by the current (pre-edge) select
    always_comb begin
        d_sel = d0;
        case (sel)
            2'd0: d_sel = d0;
            2'd1: d_sel = d1;
            2'd2: d_sel = d2;
            2'd3: d_sel = d3;
            default: d_sel = d0;
        endcase
    end

    // State, grant and datapath registers; reset dominates everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'b00;
            busy     <= 1'b0;
            z        <= '0;
            hold_cnt <= 4'd0;
            last_ptr <= 2'd3;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            sel      <= sel_nxt;
            busy     <= busy_nxt;
            hold_cnt <= hold_nxt;
            last_ptr <= last_nxt;
            z        <= busy ? d_sel : '0;
        end
    end

endmodule
